// File: rtl/user_obi_copy_mgr.sv
// Default OBI struct types for the copy engine: croc-style nested a/r channels.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package user_obi_copy_mgr_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    mgr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } mgr_obi_rsp_t;

endpackage

// Word-copy engine: register-programmed SRC/DST/LEN, copies LEN words via OBI read-then-write.
// Latency: config response 1 cycle after request; copy runs 4 cycles/word at best, irq 1 cycle after finish.
// Backpressure: config port always grants; manager port holds each request stable until gnt, one outstanding.
// Ports: clk_i/rst_ni; sbr_req_i/sbr_rsp_o config port; mgr_req_o/mgr_rsp_i copy port; done_irq_o pulse.
module user_obi_copy_mgr #(
  parameter type         sbr_obi_req_t = user_obi_copy_mgr_pkg::sbr_obi_req_t,
  parameter type         sbr_obi_rsp_t = user_obi_copy_mgr_pkg::sbr_obi_rsp_t,
  parameter type         mgr_obi_req_t = user_obi_copy_mgr_pkg::mgr_obi_req_t,
  parameter type         mgr_obi_rsp_t = user_obi_copy_mgr_pkg::mgr_obi_rsp_t,
  parameter int unsigned LenWidth      = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t sbr_req_i,
  output sbr_obi_rsp_t sbr_rsp_o,
  output mgr_obi_req_t mgr_req_o,
  input  mgr_obi_rsp_t mgr_rsp_i,
  output logic         done_irq_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [31:0]         cur_src_q, cur_src_d;
  logic [31:0]         cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0] remaining_q, remaining_d;
  logic [31:0]         data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                irq_q, irq_d;
  sbr_obi_rsp_t        rsp_q, rsp_d;

  logic       busy;
  logic       addr_ok;
  logic [1:0] reg_sel;
  logic       cfg_wr;
  logic       start;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign busy    = (state_q != IDLE);
  assign addr_ok = (sbr_req_i.a.addr[11:4] == 8'h00);
  assign reg_sel = sbr_req_i.a.addr[3:2];
  assign cfg_wr  = sbr_req_i.req && sbr_req_i.a.we && addr_ok;
  // Start is only honoured from IDLE; a start while copying is dropped.
  assign start   = cfg_wr && (reg_sel == 2'd3) && sbr_req_i.a.wdata[0] && !busy;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    done_d      = done_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    rsp_d       = '0;

    // Config response: registered, one cycle after each request.
    // Status reflects pre-update values when it collides with completion.
    rsp_d.rvalid = sbr_req_i.req;
    rsp_d.r.rid  = sbr_req_i.a.aid;
    if (sbr_req_i.req) begin
      if (!addr_ok) begin
        rsp_d.r.err = 1'b1;
      end else if (!sbr_req_i.a.we) begin
        case (reg_sel)
          2'd0:    rsp_d.r.rdata = {src_q[31:2], 2'b00};
          2'd1:    rsp_d.r.rdata = {dst_q[31:2], 2'b00};
          2'd2:    rsp_d.r.rdata = 32'(len_q);
          default: rsp_d.r.rdata = {29'd0, err_q, done_q, busy};
        endcase
      end
    end

    // Address/length registers are frozen while a copy is running.
    if (cfg_wr && !busy) begin
      case (reg_sel)
        2'd0:    src_d = be_merge(src_q, sbr_req_i.a.wdata, sbr_req_i.a.be) & 32'hFFFF_FFFC;
        2'd1:    dst_d = be_merge(dst_q, sbr_req_i.a.wdata, sbr_req_i.a.be) & 32'hFFFF_FFFC;
        2'd2:    len_d = LenWidth'(be_merge(32'(len_q), sbr_req_i.a.wdata, sbr_req_i.a.be));
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (len_q == '0) begin
            done_d = 1'b1;
            irq_d  = 1'b1;
          end else begin
            cur_src_d   = src_q;
            cur_dst_d   = dst_q;
            remaining_d = len_q;
            state_d     = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mgr_rsp_i.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mgr_rsp_i.rvalid) begin
          if (mgr_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = mgr_rsp_i.r.rdata;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mgr_rsp_i.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mgr_rsp_i.rvalid) begin
          if (mgr_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cur_src_d   = cur_src_q + 32'd4;
            cur_dst_d   = cur_dst_q + 32'd4;
            remaining_d = remaining_q - LenWidth'(1);
            if (remaining_q == LenWidth'(1)) begin
              done_d  = 1'b1;
              irq_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      rsp_q       <= rsp_d;
    end
  end

  always_comb begin
    sbr_rsp_o     = rsp_q;
    sbr_rsp_o.gnt = 1'b1;
  end

  // Request fields derive only from flops, so they stay stable until gnt
  // and vanish as soon as reset asserts.
  always_comb begin
    mgr_req_o = '0;
    if (state_q == RD_REQ || state_q == WR_REQ) begin
      mgr_req_o.req     = 1'b1;
      mgr_req_o.a.we    = (state_q == WR_REQ);
      mgr_req_o.a.be    = 4'hF;
      mgr_req_o.a.addr  = (state_q == WR_REQ) ? cur_dst_q : cur_src_q;
      mgr_req_o.a.wdata = (state_q == WR_REQ) ? data_q : 32'h0;
    end
  end

  assign done_irq_o = irq_q;

  logic unused_bits;
  assign unused_bits = ^{sbr_req_i.a.addr[31:12], sbr_req_i.a.addr[1:0], mgr_rsp_i.r.rid};

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
module tb_user_obi_copy_mgr;
  import user_obi_copy_mgr_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  sbr_obi_req_t sbr_req = '0;
  sbr_obi_rsp_t sbr_rsp;
  mgr_obi_req_t mgr_req;
  mgr_obi_rsp_t mgr_rsp = '0;
  logic         irq;

  always #5 clk = ~clk;

  user_obi_copy_mgr #(
    .sbr_obi_req_t(sbr_obi_req_t),
    .sbr_obi_rsp_t(sbr_obi_rsp_t),
    .mgr_obi_req_t(mgr_obi_req_t),
    .mgr_obi_rsp_t(mgr_obi_rsp_t),
    .LenWidth(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sbr_req_i(sbr_req),
    .sbr_rsp_o(sbr_rsp),
    .mgr_req_o(mgr_req),
    .mgr_rsp_i(mgr_rsp),
    .done_irq_o(irq)
  );

  int checks = 0;
  int errors = 0;

  // Bus memory model knobs and observations
  int          gnt_max = 0, rv_min = 1, rv_max = 1, err_read_idx = 0;
  bit          hold_gnt = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] mem [logic [31:0]];
  logic [64:0] tr [$];      // {we, addr, wdata} per granted request
  logic [64:0] exp_q [$];
  int          stab_viol = 0, outst_viol = 0, attr_viol = 0, irq_cnt = 0, read_cnt = 0;

  bit          pending = 0, stalled = 0;
  int          rsp_cnt = 0, gnt_wait = 0;
  logic [31:0] st_addr, st_wdata, rsp_rdata;
  logic        st_we, rsp_err;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt ^ 32'h5A5A_0F0F;
  endfunction

  // Reference: the copy is a list of (read src+4i, write dst+4i with that word),
  // truncated at the erroring read.
  function automatic void model_copy(input logic [31:0] src, input logic [31:0] dst,
                                     input int len, input int err_idx);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] s;
      s = src + 32'(4 * i);
      exp_q.push_back({1'b0, s, 32'h0});
      if (i + 1 == err_idx) break;
      exp_q.push_back({1'b1, dst + 32'(4 * i), init_word(s)});
    end
  endfunction

  always @(negedge clk) begin
    mgr_rsp = '0;
    if (!rst_n) begin
      pending = 0;
      stalled = 0;
    end else begin
      if (irq) irq_cnt++;
      if (pending) begin
        if (mgr_req.req) outst_viol++;
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mgr_rsp.rvalid  = 1'b1;
          mgr_rsp.r.rdata = rsp_rdata;
          mgr_rsp.r.err   = rsp_err;
          pending = 0;
        end
      end else if (mgr_req.req) begin
        if (!stalled) begin
          stalled  = 1;
          st_addr  = mgr_req.a.addr;
          st_we    = mgr_req.a.we;
          st_wdata = mgr_req.a.wdata;
          gnt_wait = int'($urandom_range(gnt_max, 0));
          if (mgr_req.a.be !== 4'hF || mgr_req.a.aid !== 1'b0) attr_viol++;
        end else if (mgr_req.a.addr !== st_addr || mgr_req.a.we !== st_we ||
                     mgr_req.a.wdata !== st_wdata) begin
          stab_viol++;
        end
        if (!hold_gnt) begin
          if (gnt_wait == 0) begin
            mgr_rsp.gnt = 1'b1;
            stalled = 0;
            tr.push_back({st_we, st_addr, st_we ? st_wdata : 32'h0});
            if (st_we) begin
              mem[st_addr] = st_wdata;
              rsp_rdata = 32'h0;
              rsp_err   = 1'b0;
            end else begin
              read_cnt++;
              rsp_rdata = mem.exists(st_addr) ? mem[st_addr] : init_word(st_addr);
              rsp_err   = (read_cnt == err_read_idx);
            end
            pending = 1;
            rsp_cnt = int'($urandom_range(rv_max, rv_min));
          end else begin
            gnt_wait--;
          end
        end
      end
    end
  end

  task automatic clear_bus(input int gmax, input int rmin, input int rmax, input int eidx);
    gnt_max = gmax; rv_min = rmin; rv_max = rmax; err_read_idx = eidx;
    tr.delete(); mem.delete();
    read_cnt = 0; stab_viol = 0; outst_viol = 0; attr_viol = 0;
    salt = $urandom;
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    sbr_req = '0;
    sbr_req.req     = 1'b1;
    sbr_req.a.addr  = addr;
    sbr_req.a.we    = 1'b1;
    sbr_req.a.be    = be;
    sbr_req.a.wdata = data;
    sbr_req.a.aid   = 4'($urandom);
    @(negedge clk);
    sbr_req = '0;
  endtask

  task automatic cfg_read(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic err, output logic rvld, output logic rid_ok);
    logic [3:0] aid;
    aid = 4'($urandom);
    @(negedge clk);
    sbr_req = '0;
    sbr_req.req    = 1'b1;
    sbr_req.a.addr = addr;
    sbr_req.a.be   = 4'hF;
    sbr_req.a.aid  = aid;
    @(negedge clk);
    rvld   = sbr_rsp.rvalid;
    rdata  = sbr_rsp.r.rdata;
    err    = sbr_rsp.r.err;
    rid_ok = (sbr_rsp.r.rid === aid);
    sbr_req = '0;
  endtask

  task automatic wait_irq(input int start_cnt, input int budget, output int cycles, output bit timeout);
    cycles = 0;
    timeout = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      cycles++;
      if (irq_cnt > start_cnt) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e, v, ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mgr_req !== '0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs req=%h irq=%b expected 0", mgr_req, irq);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_read(32'(4 * i), rd, e, v, ok);
      checks++;
      if (rd !== 32'h0 || e !== 1'b0 || v !== 1'b1 || ok !== 1'b1) begin
        errors++; $display("FAIL reset_reg%0d rdata=%h err=%b rvalid=%b rid_ok=%b expected 0/0/1/1", i, rd, e, v, ok);
      end
    end
    // Reset while a read request is stalled
    clear_bus(0, 1, 1, 0);
    hold_gnt = 1;
    cfg_write(32'h0, 32'h2000_0000, 4'hF);
    cfg_write(32'h8, 32'd3, 4'hF);
    cfg_write(32'hC, 32'd1, 4'hF);
    checks++;
    if (mgr_req.req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_req_pre req=%b expected 1", mgr_req.req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mgr_req.req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req_drop req=%b expected 0", mgr_req.req);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_gnt = 0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (tr.size() != 0 || mgr_req.req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_traffic txns=%0d req=%b expected 0/0", tr.size(), mgr_req.req);
    end
    cfg_read(32'h8, rd, e, v, ok);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL rst_mid_len rdata=%h expected 0", rd);
    end
  endtask

  task automatic test_basic();
    int c0, cyc; bit to; logic [31:0] rd; logic e, v, ok;
    logic [31:0] src, dst;
    src = 32'h1000_0000; dst = 32'h1000_0100;
    clear_bus(0, 1, 1, 0);
    cfg_write(32'h0, src, 4'hF);
    cfg_write(32'h4, dst, 4'hF);
    cfg_write(32'h8, 32'd4, 4'hF);
    c0 = irq_cnt;
    cfg_write(32'hC, 32'd1, 4'hF);
    wait_irq(c0, 200, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout irq not seen within 200 cycles"); end
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL basic_latency cycles=%0d expected 16", cyc); end
    repeat (5) @(negedge clk); #1;
    checks++;
    if (irq_cnt != c0 + 1) begin errors++; $display("FAIL basic_irq pulses=%0d expected 1", irq_cnt - c0); end
    cfg_read(32'hC, rd, e, v, ok);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL basic_status got %h expected 2", rd); end
    model_copy(src, dst, 4, 0);
    checks++;
    if (tr.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_txn_count got %0d expected %0d", tr.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= tr.size() || tr[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_txn%0d got %h expected %h", i, (i < tr.size()) ? tr[i] : 65'h0, exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!mem.exists(dst + 32'(4 * i)) || mem[dst + 32'(4 * i)] !== init_word(src + 32'(4 * i))) begin
        errors++; $display("FAIL basic_dst_word%0d expected %h", i, init_word(src + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int c0, cyc; bit to; logic [31:0] rd; logic e, v, ok;
    logic [31:0] src, dst;
    for (int it = 0; it < 2; it++) begin
      clear_bus(5, 1, 5, 0);
      src = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
      dst = src ^ 32'h0100_0000;
      cfg_write(32'h0, src, 4'hF);
      cfg_write(32'h4, dst, 4'hF);
      cfg_write(32'h8, 32'd8, 4'hF);
      c0 = irq_cnt;
      cfg_write(32'hC, 32'd1, 4'hF);
      wait_irq(c0, 1000, cyc, to);
      checks++;
      if (to) begin errors++; $display("FAIL bp_timeout iter=%0d", it); end
      repeat (3) @(negedge clk); #1;
      checks++;
      if (stab_viol != 0 || outst_viol != 0 || attr_viol != 0) begin
        errors++; $display("FAIL bp_protocol stable=%0d outstanding=%0d attr=%0d expected 0/0/0", stab_viol, outst_viol, attr_viol);
      end
      checks++;
      if (irq_cnt != c0 + 1) begin errors++; $display("FAIL bp_irq pulses=%0d expected 1", irq_cnt - c0); end
      model_copy(src, dst, 8, 0);
      checks++;
      if (tr.size() != exp_q.size()) begin
        errors++; $display("FAIL bp_txn_count got %0d expected %0d", tr.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= tr.size() || tr[i] !== exp_q[i]) begin
          errors++; $display("FAIL bp_txn%0d got %h expected %h", i, (i < tr.size()) ? tr[i] : 65'h0, exp_q[i]);
        end
      end
      cfg_read(32'hC, rd, e, v, ok);
      checks++;
      if (rd !== 32'h2) begin errors++; $display("FAIL bp_status got %h expected 2", rd); end
    end
  endtask

  task automatic test_error_abort();
    int c0, cyc; bit to; logic [31:0] rd; logic e, v, ok;
    logic [31:0] src, dst;
    src = 32'h1000_2000; dst = 32'h1000_3000;
    clear_bus(2, 1, 3, 3);
    cfg_write(32'h0, src, 4'hF);
    cfg_write(32'h4, dst, 4'hF);
    cfg_write(32'h8, 32'd5, 4'hF);
    c0 = irq_cnt;
    cfg_write(32'hC, 32'd1, 4'hF);
    wait_irq(c0, 500, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL abort_timeout"); end
    repeat (20) @(negedge clk); #1;
    checks++;
    if (irq_cnt != c0 + 1 || mgr_req.req !== 1'b0) begin
      errors++; $display("FAIL abort_irq_req pulses=%0d req=%b expected 1/0", irq_cnt - c0, mgr_req.req);
    end
    model_copy(src, dst, 5, 3);
    checks++;
    if (tr.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_txn_count got %0d expected %0d", tr.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= tr.size() || tr[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_txn%0d got %h expected %h", i, (i < tr.size()) ? tr[i] : 65'h0, exp_q[i]);
      end
    end
    cfg_read(32'hC, rd, e, v, ok);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL abort_status got %h expected 6", rd); end
    err_read_idx = 0;
  endtask

  task automatic test_len0_busy_guard();
    int c0, cyc; bit to; logic [31:0] rd; logic e, v, ok;
    logic [31:0] src, dst;
    clear_bus(0, 1, 1, 0);
    cfg_write(32'h8, 32'd0, 4'hF);
    c0 = irq_cnt;
    cfg_write(32'hC, 32'd1, 4'hF);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL len0_irq_timing irq=%b expected 1", irq); end
    cfg_read(32'hC, rd, e, v, ok);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL len0_status got %h expected 2", rd); end
    repeat (5) @(negedge clk); #1;
    checks++;
    if (tr.size() != 0 || irq_cnt != c0 + 1) begin
      errors++; $display("FAIL len0_traffic txns=%0d pulses=%0d expected 0/1", tr.size(), irq_cnt - c0);
    end
    // Busy guard: reprogram SRC and restart mid-copy
    src = 32'h3000_0000; dst = 32'h3000_1000;
    clear_bus(3, 1, 3, 0);
    cfg_write(32'h0, src, 4'hF);
    cfg_write(32'h4, dst, 4'hF);
    cfg_write(32'h8, 32'd3, 4'hF);
    c0 = irq_cnt;
    cfg_write(32'hC, 32'd1, 4'hF);
    cfg_read(32'hC, rd, e, v, ok);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL guard_busy_status got %h expected 1", rd); end
    cfg_write(32'h0, 32'hDEAD_BEEF, 4'hF);
    cfg_write(32'hC, 32'd1, 4'hF);
    wait_irq(c0, 500, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL guard_timeout"); end
    repeat (10) @(negedge clk); #1;
    checks++;
    if (irq_cnt != c0 + 1) begin errors++; $display("FAIL guard_irq pulses=%0d expected 1", irq_cnt - c0); end
    cfg_read(32'h0, rd, e, v, ok);
    checks++;
    if (rd !== src || e !== 1'b0) begin errors++; $display("FAIL guard_src got %h err=%b expected %h/0", rd, e, src); end
    model_copy(src, dst, 3, 0);
    checks++;
    if (tr.size() != exp_q.size()) begin
      errors++; $display("FAIL guard_txn_count got %0d expected %0d", tr.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= tr.size() || tr[i] !== exp_q[i]) begin
        errors++; $display("FAIL guard_txn%0d got %h expected %h", i, (i < tr.size()) ? tr[i] : 65'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_decode_wrap();
    int c0, cyc; bit to; logic [31:0] rd; logic e, v, ok;
    cfg_read(32'h10, rd, e, v, ok);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || v !== 1'b1 || ok !== 1'b1) begin
      errors++; $display("FAIL decode_0x10 err=%b rdata=%h rvalid=%b rid_ok=%b expected 1/0/1/1", e, rd, v, ok);
    end
    cfg_write(32'h0, 32'hFFFF_FFFF, 4'hF);
    cfg_write(32'h10, 32'h5555_5554, 4'hF);
    cfg_write(32'h0, 32'h1234_567B, 4'b0101);
    cfg_read(32'h0, rd, e, v, ok);
    checks++;
    if (rd !== 32'hFF34_FF78) begin errors++; $display("FAIL decode_src_be got %h expected ff34ff78", rd); end
    cfg_write(32'h8, 32'h0000_FFFF, 4'hF);
    cfg_write(32'h8, 32'hABCD_1234, 4'b1110);
    cfg_read(32'h808, rd, e, v, ok);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL decode_0x808 err=%b rdata=%h expected 1/0", e, rd); end
    cfg_read(32'h8, rd, e, v, ok);
    checks++;
    if (rd !== 32'h0000_12FF) begin errors++; $display("FAIL decode_len_be got %h expected 000012ff", rd); end
    // Address wrap
    clear_bus(0, 1, 1, 0);
    cfg_write(32'h0, 32'hFFFF_FFFC, 4'hF);
    cfg_write(32'h4, 32'h0000_0100, 4'hF);
    cfg_write(32'h8, 32'd2, 4'hF);
    c0 = irq_cnt;
    cfg_write(32'hC, 32'd1, 4'hF);
    wait_irq(c0, 200, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL wrap_timeout"); end
    checks++;
    if (tr.size() < 3 || tr[2][63:32] !== 32'h0) begin
      errors++; $display("FAIL wrap_second_read txns=%0d addr=%h expected 0", tr.size(), (tr.size() >= 3) ? tr[2][63:32] : 32'hX);
    end
    model_copy(32'hFFFF_FFFC, 32'h0000_0100, 2, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= tr.size() || tr[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_txn%0d got %h expected %h", i, (i < tr.size()) ? tr[i] : 65'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error_abort();
    test_len0_busy_guard();
    test_decode_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
